// File: rtl/i2c_bus_arbiter.sv
// Round-robin front end sharing one i2c_master byte engine between two requesters,
// with retry on master error, a per-attempt watchdog and a req/ack return path.
module i2c_bus_arbiter #(
    parameter logic [6:0]  DEV_ADDR  = 7'h50,
    parameter int unsigned MAX_RETRY = 2,
    parameter int unsigned RETRY_GAP = 200,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [7:0] baddr0,
    input  logic [7:0] baddr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic [1:0] status,
    output logic       busy,
    output logic       m_start,
    output logic       m_rw,
    output logic [6:0] m_addr,
    output logic [7:0] m_byte_address,
    output logic [7:0] m_din,
    input  logic [7:0] m_dout,
    input  logic       m_byte_done,
    input  logic       m_error
);
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERROR   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_RESPOND
    } state_t;

    state_t      r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic [7:0]  r_attempts;
    logic [15:0] r_tmo_cnt;
    logic [15:0] r_gap_cnt;
    logic        r_done_q;
    logic        r_done_q2;
    logic        r_err_q;
    logic        r_err_q2;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_busy;
    logic        r_m_start;
    logic        r_m_rw;
    logic [7:0]  r_rdata;
    logic [7:0]  r_m_baddr;
    logic [7:0]  r_m_din;
    logic [1:0]  r_status;

    logic        w_pick1;
    logic        w_done_rise;
    logic        w_err_rise;
    logic        w_tmo_hit;
    logic        w_retry_ok;
    logic        w_gap_done;
    logic [15:0] w_tmo_next;

    // With both requests pending, the requester not served last wins.
    assign w_pick1     = req1 & (~req0 | ~r_last_grant);
    assign w_done_rise = r_done_q & ~r_done_q2;
    assign w_err_rise  = r_err_q & ~r_err_q2;
    assign w_tmo_next  = r_tmo_cnt + 16'd1;
    assign w_tmo_hit   = (w_tmo_next == 16'(TIMEOUT - 1));
    assign w_retry_ok  = ({24'd0, r_attempts} < MAX_RETRY);
    assign w_gap_done  = (({16'd0, r_gap_cnt} + 32'd1) >= RETRY_GAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q  <= 1'b0;
            r_done_q2 <= 1'b0;
            r_err_q   <= 1'b0;
            r_err_q2  <= 1'b0;
        end else begin
            r_done_q  <= m_byte_done;
            r_done_q2 <= r_done_q;
            r_err_q   <= m_error;
            r_err_q2  <= r_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_attempts   <= 8'd0;
            r_tmo_cnt    <= 16'd0;
            r_gap_cnt    <= 16'd0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_busy       <= 1'b0;
            r_m_start    <= 1'b0;
            r_m_rw       <= 1'b0;
            r_rdata      <= 8'd0;
            r_m_baddr    <= 8'd0;
            r_m_din      <= 8'd0;
            r_status     <= ST_OK;
        end else begin
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_m_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_grant    <= w_pick1;
                        r_m_rw     <= w_pick1 ? rw1 : rw0;
                        r_m_baddr  <= w_pick1 ? baddr1 : baddr0;
                        r_m_din    <= w_pick1 ? wdata1 : wdata0;
                        r_busy     <= 1'b1;
                        r_attempts <= 8'd0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The master must be back in its idle state before a new start.
                    if (!m_byte_done && !m_error) begin
                        r_m_start <= 1'b1;
                        r_tmo_cnt <= 16'd0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_done_rise) begin
                        if (r_m_rw) begin
                            r_rdata <= m_dout;
                        end
                        r_status <= ST_OK;
                        r_state  <= S_RESPOND;
                    end else if (w_err_rise) begin
                        if (w_retry_ok) begin
                            r_attempts <= r_attempts + 8'd1;
                            r_gap_cnt  <= 16'd0;
                            r_state    <= S_GAP;
                        end else begin
                            r_status <= ST_ERROR;
                            r_state  <= S_RESPOND;
                        end
                    end else if (w_tmo_hit) begin
                        r_status <= ST_TIMEOUT;
                        r_state  <= S_RESPOND;
                    end else begin
                        r_tmo_cnt <= w_tmo_next;
                    end
                end
                S_GAP: begin
                    if (w_gap_done) begin
                        r_state <= S_ISSUE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                S_RESPOND: begin
                    r_ack0       <= ~r_grant;
                    r_ack1       <= r_grant;
                    r_last_grant <= r_grant;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack0           = r_ack0;
    assign ack1           = r_ack1;
    assign rdata          = r_rdata;
    assign status         = r_status;
    assign busy           = r_busy;
    assign m_start        = r_m_start;
    assign m_rw           = r_m_rw;
    assign m_addr         = DEV_ADDR;
    assign m_byte_address = r_m_baddr;
    assign m_din          = r_m_din;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: a slave model of the i2c_master, a directed vector
// table, hand sequences for arbitration/reset, and random transactions vs a reference model.
`timescale 1ns/1ps
module tb_i2c_bus_arbiter;
    localparam int MAX_RETRY = 2;
    localparam int RETRY_GAP = 50;
    localparam int TIMEOUT   = 1000;
    localparam int OK   = 0;
    localparam int ERR  = 1;
    localparam int HANG = 2;
    localparam int BOTH = 3;

    typedef struct {
        int         who;
        logic       rw;
        logic [7:0] baddr;
        logic [7:0] wdata;
        logic [7:0] dout;
        int         p0;
        int         p1;
        int         p2;
        logic [1:0] expStatus;
        int         expStarts;
        logic [7:0] expRdata;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
    logic [7:0] baddr0 = 8'd0, baddr1 = 8'd0, wdata0 = 8'd0, wdata1 = 8'd0;
    logic       ack0, ack1, busy, m_start, m_rw;
    logic [7:0] rdata, m_byte_address, m_din;
    logic [1:0] status;
    logic [6:0] m_addr;
    logic [7:0] m_dout = 8'd0;
    logic       m_byte_done = 1'b0, m_error = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int planQ[$];
    int startCyc[$];
    int riseCyc = 0;
    int holdCycles = 6;
    int sState = 0, sCnt = 0, sKind = OK;
    logic [7:0] slaveDout = 8'd0;
    logic       expRw = 1'b0;
    logic [7:0] expBaddr = 8'd0, expDin = 8'd0;
    logic [7:0] modelRdata = 8'd0;
    vec_t       vecs [9];

    i2c_bus_arbiter #(
        .DEV_ADDR (7'h50),
        .MAX_RETRY(MAX_RETRY),
        .RETRY_GAP(RETRY_GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .baddr0(baddr0), .baddr1(baddr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .status(status), .busy(busy),
        .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr),
        .m_byte_address(m_byte_address), .m_din(m_din),
        .m_dout(m_dout), .m_byte_done(m_byte_done), .m_error(m_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model of the i2c_master: each start consumes one planned outcome.
    initial begin : slaveModel
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                sState = 0;
                m_byte_done = 1'b0;
                m_error = 1'b0;
            end else begin
                case (sState)
                    0: if (m_start) begin
                        startCyc.push_back(cyc);
                        checkOutput("m_rw", 32'(m_rw), 32'(expRw));
                        checkOutput("m_byte_address", 32'(m_byte_address), 32'(expBaddr));
                        checkOutput("m_din", 32'(m_din), 32'(expDin));
                        checkOutput("m_addr", 32'(m_addr), 32'h50);
                        checkOutput("busy_at_start", 32'(busy), 32'd1);
                        sKind = (planQ.size() > 0) ? planQ.pop_front() : OK;
                        if (sKind != HANG) begin
                            sState = 1;
                            sCnt = int'($urandom_range(2, 5));
                        end
                    end
                    1: begin
                        sCnt--;
                        if (sCnt == 0) begin
                            if (sKind == OK || sKind == BOTH) begin
                                m_dout = slaveDout;
                                m_byte_done = 1'b1;
                            end
                            if (sKind == ERR || sKind == BOTH) m_error = 1'b1;
                            riseCyc = cyc;
                            sState = 2;
                            sCnt = holdCycles;
                        end
                    end
                    default: begin
                        sCnt--;
                        if (sCnt == 0) begin
                            m_byte_done = 1'b0;
                            m_error = 1'b0;
                            sState = 0;
                        end
                    end
                endcase
            end
        end
    end

    function automatic int pick(input int lastG, input bit r0, input bit r1);
        if (r0 && r1) return (lastG == 1) ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    // Attempt-level model: walk the planned outcomes until one ends the transaction.
    function automatic void refTxn(input vec_t v, inout logic [7:0] mRd,
                                   output logic [1:0] st, output int starts);
        int plan [3];
        plan[0] = v.p0; plan[1] = v.p1; plan[2] = v.p2;
        st = 2'b00;
        starts = 0;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            starts = a + 1;
            if (plan[a] == OK || plan[a] == BOTH) begin
                if (v.rw) mRd = v.dout;
                return;
            end
            if (plan[a] == HANG) begin
                st = 2'b10;
                return;
            end
            if (a == MAX_RETRY) begin
                st = 2'b01;
                return;
            end
        end
    endfunction

    task automatic waitAck(input int limit, output int who, output logic [7:0] rd,
                           output logic [1:0] st, output int ackAt, output bit timedOut);
        who = -1; rd = 8'd0; st = 2'b00; ackAt = 0; timedOut = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                who = (ack0 && ack1) ? 2 : (ack1 ? 1 : 0);
                rd = rdata;
                st = status;
                ackAt = cyc;
                timedOut = 1'b0;
                break;
            end
        end
        if (timedOut) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_wait: no ack within %0d cycles", limit);
        end
    endtask

    task automatic resetChecks(input string tag);
        checkOutput({tag, "_ack0"}, 32'(ack0), 32'd0);
        checkOutput({tag, "_ack1"}, 32'(ack1), 32'd0);
        checkOutput({tag, "_m_start"}, 32'(m_start), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_rdata"}, 32'(rdata), 32'd0);
        checkOutput({tag, "_status"}, 32'(status), 32'd0);
        checkOutput({tag, "_m_rw"}, 32'(m_rw), 32'd0);
        checkOutput({tag, "_m_byte_address"}, 32'(m_byte_address), 32'd0);
        checkOutput({tag, "_m_din"}, 32'(m_din), 32'd0);
        checkOutput({tag, "_m_addr"}, 32'(m_addr), 32'h50);
    endtask

    task automatic applyStimulus(input vec_t v);
        int base, gotWho, ackAt, finalKind;
        logic [7:0] gotRd;
        logic [1:0] gotSt;
        bit to;
        int plan [3];
        plan[0] = v.p0; plan[1] = v.p1; plan[2] = v.p2;
        planQ.delete();
        for (int i = 0; i < 3; i++) planQ.push_back(plan[i]);
        slaveDout = v.dout; expRw = v.rw; expBaddr = v.baddr; expDin = v.wdata;
        base = startCyc.size();
        @(negedge clk);
        if (v.who == 0) begin
            req0 = 1'b1; rw0 = v.rw; baddr0 = v.baddr; wdata0 = v.wdata;
        end else begin
            req1 = 1'b1; rw1 = v.rw; baddr1 = v.baddr; wdata1 = v.wdata;
        end
        waitAck(6000, gotWho, gotRd, gotSt, ackAt, to);
        req0 = 1'b0;
        req1 = 1'b0;
        if (!to) begin
            checkOutput("ack_who", 32'(gotWho), 32'(v.who));
            checkOutput("ack_status", 32'(gotSt), 32'(v.expStatus));
            checkOutput("ack_rdata", 32'(gotRd), 32'(v.expRdata));
            checkOutput("start_count", 32'(startCyc.size() - base), 32'(v.expStarts));
            finalKind = plan[v.expStarts - 1];
            if (startCyc.size() > base) begin
                if (finalKind == HANG)
                    checkOutput("timeout_latency", 32'(ackAt - startCyc[$]), 32'(TIMEOUT));
                else
                    checkOutput("done_to_ack_latency", 32'(ackAt - riseCyc), 32'd3);
            end
            for (int k = base + 1; k < startCyc.size(); k++)
                checkOutput("retry_spacing_ok",
                            32'((startCyc[k] - startCyc[k-1]) >= RETRY_GAP + 1), 32'd1);
            @(negedge clk);
            checkOutput("ack_one_cycle", 32'({ack0, ack1}), 32'd0);
            checkOutput("busy_after_ack", 32'(busy), 32'd0);
        end
    endtask

    // Both requesters held; each drops for one cycle after its ack and re-asserts.
    task automatic arbSequence();
        int lastG, expWho, gotWho, ackAt, base;
        int ackTimes [4];
        logic [7:0] gotRd;
        logic [1:0] gotSt;
        bit to;
        bit r0, r1;
        lastG = 1; r0 = 1'b1; r1 = 1'b1;
        planQ.delete();
        for (int i = 0; i < 4; i++) planQ.push_back(OK);
        holdCycles = 1;
        expRw = 1'b0; expBaddr = 8'h33; expDin = 8'h44;
        base = startCyc.size();
        @(negedge clk);
        rw0 = 1'b0; rw1 = 1'b0; baddr0 = 8'h33; baddr1 = 8'h33; wdata0 = 8'h44; wdata1 = 8'h44;
        req0 = 1'b1; req1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            expWho = pick(lastG, r0, r1);
            waitAck(2000, gotWho, gotRd, gotSt, ackAt, to);
            if (to) break;
            ackTimes[t] = ackAt;
            checkOutput("arb_grant", 32'(gotWho), 32'(expWho));
            checkOutput("arb_status", 32'(gotSt), 32'd0);
            lastG = expWho;
            if (t == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (gotWho == 0) req0 = 1'b0; else req1 = 1'b0;
                r0 = (expWho != 0); r1 = (expWho != 1);
                @(negedge clk);
                req0 = 1'b1; req1 = 1'b1;
                if (t < 3 && startCyc.size() == base + t + 1) begin
                    r0 = 1'b1; r1 = 1'b1;
                end
                r0 = (expWho != 0) || r0;
                r1 = (expWho != 1) || r1;
                lastG = expWho;
                r0 = (lastG == 0) ? 1'b0 : 1'b1;
                r1 = (lastG == 1) ? 1'b0 : 1'b1;
            end
        end
        checkOutput("arb_start_count", 32'(startCyc.size() - base), 32'd4);
        for (int t = 1; t < 4 && base + t < startCyc.size(); t++)
            checkOutput("back_to_back_ok", 32'((startCyc[base + t] - ackTimes[t-1]) >= 2), 32'd1);
        holdCycles = 6;
        repeat (10) @(negedge clk);
    endtask

    task automatic resetSequence();
        int base, gotWho, ackAt, waitN;
        logic [7:0] gotRd;
        logic [1:0] gotSt;
        bit to, sawAck;
        planQ.delete();
        planQ.push_back(HANG);
        expRw = 1'b0; expBaddr = 8'h7E; expDin = 8'hC3;
        base = startCyc.size();
        @(negedge clk);
        req1 = 1'b1; rw1 = 1'b0; baddr1 = 8'h7E; wdata1 = 8'hC3;
        waitN = 0;
        while (startCyc.size() == base && waitN < 200) begin
            @(negedge clk);
            waitN++;
        end
        checkOutput("rst_seq_started", 32'(startCyc.size() - base), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("busy_in_wait", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 resetChecks("midreset");
        sawAck = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack0 || ack1) sawAck = 1'b1;
        end
        checkOutput("no_ack_in_reset", 32'(sawAck), 32'd0);
        planQ.delete();
        planQ.push_back(OK);
        base = startCyc.size();
        rst_n = 1'b1;
        waitAck(2000, gotWho, gotRd, gotSt, ackAt, to);
        req1 = 1'b0;
        if (!to) begin
            checkOutput("reissue_who", 32'(gotWho), 32'd1);
            checkOutput("reissue_status", 32'(gotSt), 32'd0);
            checkOutput("reissue_rdata", 32'(gotRd), 32'd0);
            checkOutput("reissue_starts", 32'(startCyc.size() - base), 32'd1);
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainTest
        vec_t v;
        vecs[0] = '{0, 1'b0, 8'h10, 8'hA5, 8'h00, OK,   OK,   OK,   2'b00, 1, 8'h00};
        vecs[1] = '{1, 1'b1, 8'h42, 8'h00, 8'h3C, OK,   OK,   OK,   2'b00, 1, 8'h3C};
        vecs[2] = '{0, 1'b0, 8'h20, 8'h11, 8'h99, ERR,  OK,   OK,   2'b00, 2, 8'h3C};
        vecs[3] = '{0, 1'b1, 8'h21, 8'h00, 8'h77, ERR,  ERR,  ERR,  2'b01, 3, 8'h3C};
        vecs[4] = '{1, 1'b1, 8'h30, 8'h00, 8'h5A, ERR,  ERR,  OK,   2'b00, 3, 8'h5A};
        vecs[5] = '{0, 1'b0, 8'h55, 8'h66, 8'h00, HANG, OK,   OK,   2'b10, 1, 8'h5A};
        vecs[6] = '{0, 1'b1, 8'hFF, 8'h00, 8'hE1, OK,   OK,   OK,   2'b00, 1, 8'hE1};
        vecs[7] = '{1, 1'b0, 8'h00, 8'hFF, 8'h00, ERR,  HANG, OK,   2'b10, 2, 8'hE1};
        vecs[8] = '{1, 1'b1, 8'h0C, 8'h00, 8'h9B, BOTH, OK,   OK,   2'b00, 1, 8'h9B};

        rst_n = 1'b0;
        #12 resetChecks("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        arbSequence();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            modelRdata = vecs[i].expRdata;
        end

        for (int n = 0; n < 25; n++) begin
            int r;
            v.who   = int'($urandom_range(0, 1));
            v.rw    = 1'($urandom_range(0, 1));
            v.baddr = 8'($urandom);
            v.wdata = 8'($urandom);
            v.dout  = 8'($urandom);
            r = int'($urandom_range(0, 99)); v.p0 = (r < 60) ? OK : ((r < 97) ? ERR : HANG);
            r = int'($urandom_range(0, 99)); v.p1 = (r < 60) ? OK : ((r < 97) ? ERR : HANG);
            r = int'($urandom_range(0, 99)); v.p2 = (r < 60) ? OK : ((r < 97) ? ERR : HANG);
            refTxn(v, modelRdata, v.expStatus, v.expStarts);
            v.expRdata = modelRdata;
            applyStimulus(v);
        end

        resetSequence();
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
